axis_route_lock: RTL
====================

# axis_route_lock

Wormhole output-selection stage for one router input port. It decodes the destination from a packet's header beat using XY or YX dimension-order routing, then locks the selected output channel until the TLAST beat has been handed over. Packets whose destination lies outside the mesh are dropped, and every forwarded beat passes through a one-beat, full-throughput register slice. It sits between an input FIFO and the per-output arbiters inside the AXI-Stream router.

## Interface
- CHANNEL_NUMBER, 5: output channels. Index 0 local, 1 north, 2 east, 3 south, 4 west.
- MAX_ROUTERS_X, 4 / MAX_ROUTERS_Y, 4: mesh dimensions.
- X_WIDTH / Y_WIDTH, $clog2 of the dimension: coordinate widths.
- ROUTER_X, 0 / ROUTER_Y, 0: this router's coordinate.
- ROUTE_MODE, ROUTE_XY: either ROUTE_XY or ROUTE_YX.
- HDR_X_LSB, 0 / HDR_Y_LSB, 8: bit positions of target x and target y in header TDATA.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset. One clock; the reset is synchronous and active-high.
- in_mosi_i  in  axis_mosi_t  upstream beat.
- in_miso_o  out  axis_miso_t  upstream TREADY.
- out_mosi_o[CHANNEL_NUMBER]  out  axis_mosi_t  per-channel beats.
- out_miso_i[CHANNEL_NUMBER]  in  axis_miso_t  per-channel TREADY.
- lock_o  out  CHANNEL_NUMBER  one-hot locked channel; all zeros when idle.
- drop_o  out  1  one-cycle pulse when a packet's TLAST is discarded.

## Operation
- FSM states:
  - IDLE:
    - On an accepted header (TID == ROUTING_HEADER): compute the channel, then go to ROUTE. If that beat also has TLAST, return to IDLE.
    - If the destination is out of range (x ≥ MAX_ROUTERS_X or y ≥ MAX_ROUTERS_Y), go to DROP instead.
    - An accepted beat whose TID ≠ ROUTING_HEADER is a protocol error and goes to DROP.
  - ROUTE: the channel stays fixed in the `sel` register. Every beat, including any beat with TID == ROUTING_HEADER, is forwarded unchanged. An accepted TLAST returns to IDLE.
  - DROP: TREADY is held at 1 and nothing is forwarded. An accepted TLAST pulses drop_o and returns to IDLE. A dropped single-beat packet pulses drop_o in the same cycle it is accepted.
- Routing order:
  - XY mode resolves x first: east if tx > ROUTER_X, west if tx < ROUTER_X. It then resolves y: south if ty > ROUTER_Y, north if ty < ROUTER_Y. If both match, the channel is local.
  - YX mode resolves y first, then x.
- Register slice holds `{valid, beat, channel}`:
  - It accepts a new beat when empty, or when the target channel's TREADY pops the current beat in the same cycle.
  - Upstream TREADY = `!valid || out_miso_i[channel].TREADY`.
  - In DROP state, upstream TREADY = 1.
- Output channels:
  - Only `out_mosi_o[channel]` carries the register contents. All other channels drive '0.
  - The channel is stored per beat, so a new header may take a different channel while the previous TLAST is still held in the slice.
- lock_o is the one-hot form of `sel` while in ROUTE. It is all zeros in IDLE and DROP.

## Timing
- Reset: FSM goes to IDLE, slice valid = 0. All out_mosi_o = '0, in_miso_o.TREADY = 1, lock_o = 0, drop_o = 0.
- Latency: an accepted beat appears on its output one cycle later.
- Throughput: one beat per cycle while downstream is ready.
- Backpressure:
  - Held output beats stay stable until that channel's TREADY is seen.
  - TVALID is never withdrawn while the beat is unaccepted.
- Reset mid-packet: the slice and state are discarded. The remaining beats of that packet then arrive in IDLE without a header and are dropped.
- Simultaneous events:
  - A TLAST pop and a new header acceptance can happen in the same cycle with no bubble.
  - IDLE → ROUTE transitions on the header's own acceptance cycle.

## Structure
- Package `router_pkg` holds:
  - the `route_mode_e` enum (ROUTE_XY, ROUTE_YX);
  - channel index constants CH_LOCAL, CH_NORTH, CH_EAST, CH_SOUTH, CH_WEST;
  - ROUTING_HEADER;
  - the FSM state enum (IDLE, ROUTE, DROP).
- Sub-module `route_compute` is combinational. It takes tx/ty plus the parameters and returns the channel index and an out-of-range flag.
- The FSM and the register slice stay in this module.

## Test plan
- ROUTER (1,1), XY mode, header to (3,0) with 4 beats, all outputs ready -> beats appear on channel 2 (east) at cycles +1..+4; lock_o = 5'b00100 until TLAST.
- Same header in YX mode -> beats go to channel 1 (north).
- Header to (1,1) with a single beat, TLAST=1 -> one beat on channel 0; the FSM stays in IDLE; lock_o never asserts.
- Header to (5,0) in a 4×4 mesh with 3 beats -> nothing is forwarded; TREADY=1 throughout; drop_o pulses exactly once, on the TLAST cycle.
- East TREADY held low for 3 cycles mid-packet -> output beat held stable, upstream TREADY=0; no beat lost or duplicated; payload matches after release.
- Back-to-back packets east then south, with the east TREADY low while its TLAST is held -> the south header does not overtake; the south packet is forwarded with no bubble after the east TLAST pops. Assert rst_i mid-packet -> all outputs go to reset values on the next cycle.

Source files
------------

// File: rtl/router_pkg.sv
// Shared types and constants for the AXI-Stream mesh router: beat structs,
// channel indices, routing mode and the route-lock FSM states.
package router_pkg;

  typedef enum logic {ROUTE_XY, ROUTE_YX} route_mode_e;

  localparam int TDATA_W = 32;
  localparam int TID_W   = 4;
  localparam int CH_W    = 3;
  // Header coordinate fields are wider than the mesh so bad targets stay visible.
  localparam int COORD_W = 8;

  localparam logic [CH_W-1:0] CH_LOCAL = 3'd0;
  localparam logic [CH_W-1:0] CH_NORTH = 3'd1;
  localparam logic [CH_W-1:0] CH_EAST  = 3'd2;
  localparam logic [CH_W-1:0] CH_SOUTH = 3'd3;
  localparam logic [CH_W-1:0] CH_WEST  = 3'd4;

  localparam logic [TID_W-1:0] ROUTING_HEADER = 4'hA;

  typedef struct packed {
    logic               tvalid;
    logic [TDATA_W-1:0] tdata;
    logic [TID_W-1:0]   tid;
    logic               tlast;
  } axis_mosi_t;

  typedef struct packed {
    logic tready;
  } axis_miso_t;

  typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_e;

endpackage

// File: rtl/route_compute.sv
// Dimension-order route decode: maps a target (tx, ty) to an output channel
// and flags targets that fall outside the mesh.
module route_compute
  import router_pkg::*;
#(
  parameter int          MAX_ROUTERS_X = 4,
  parameter int          MAX_ROUTERS_Y = 4,
  parameter int          X_WIDTH       = $clog2(MAX_ROUTERS_X),
  parameter int          Y_WIDTH       = $clog2(MAX_ROUTERS_Y),
  parameter int          ROUTER_X      = 0,
  parameter int          ROUTER_Y      = 0,
  parameter route_mode_e ROUTE_MODE    = ROUTE_XY
) (
  input  logic [COORD_W-1:0] tx_i,
  input  logic [COORD_W-1:0] ty_i,
  output logic [CH_W-1:0]    ch_o,
  output logic               oor_o
);

  localparam logic [X_WIDTH-1:0] RX = X_WIDTH'(ROUTER_X);
  localparam logic [Y_WIDTH-1:0] RY = Y_WIDTH'(ROUTER_Y);

  logic x_gt, x_lt, y_gt, y_lt;

  // Once the range check passes only the low coordinate bits matter.
  assign oor_o = (tx_i >= COORD_W'(MAX_ROUTERS_X)) || (ty_i >= COORD_W'(MAX_ROUTERS_Y));
  assign x_gt  = tx_i[X_WIDTH-1:0] > RX;
  assign x_lt  = tx_i[X_WIDTH-1:0] < RX;
  assign y_gt  = ty_i[Y_WIDTH-1:0] > RY;
  assign y_lt  = ty_i[Y_WIDTH-1:0] < RY;

  // NOTE: default assignment first so every path drives ch_o and no latch is inferred.
  always_comb begin
    ch_o = CH_LOCAL;
    if (ROUTE_MODE == ROUTE_XY) begin
      if      (x_gt) ch_o = CH_EAST;
      else if (x_lt) ch_o = CH_WEST;
      else if (y_gt) ch_o = CH_SOUTH;
      else if (y_lt) ch_o = CH_NORTH;
    end else begin
      if      (y_gt) ch_o = CH_SOUTH;
      else if (y_lt) ch_o = CH_NORTH;
      else if (x_gt) ch_o = CH_EAST;
      else if (x_lt) ch_o = CH_WEST;
    end
  end

endmodule

// File: rtl/axis_route_lock.sv
// Wormhole output selection for one router input: decodes the header, locks
// the output until TLAST, drops unroutable packets, one-beat register slice.
module axis_route_lock
  import router_pkg::*;
#(
  parameter int          CHANNEL_NUMBER = 5,
  parameter int          MAX_ROUTERS_X  = 4,
  parameter int          MAX_ROUTERS_Y  = 4,
  parameter int          X_WIDTH        = $clog2(MAX_ROUTERS_X),
  parameter int          Y_WIDTH        = $clog2(MAX_ROUTERS_Y),
  parameter int          ROUTER_X       = 0,
  parameter int          ROUTER_Y       = 0,
  parameter route_mode_e ROUTE_MODE     = ROUTE_XY,
  parameter int          HDR_X_LSB      = 0,
  parameter int          HDR_Y_LSB      = 8
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  axis_mosi_t                in_mosi_i,
  output axis_miso_t                in_miso_o,
  output axis_mosi_t                out_mosi_o [CHANNEL_NUMBER],
  input  axis_miso_t                out_miso_i [CHANNEL_NUMBER],
  output logic [CHANNEL_NUMBER-1:0] lock_o,
  output logic                      drop_o
);

  state_e          state_q;
  logic [CH_W-1:0] sel_q;
  logic            valid_q;
  axis_mosi_t      beat_q;
  logic [CH_W-1:0] ch_q;

  logic [CH_W-1:0] route_ch, load_ch;
  logic            oor, is_hdr, fwd_ok, in_acc, load, pop, sel_ready, in_ready;

  route_compute #(
    .MAX_ROUTERS_X(MAX_ROUTERS_X),
    .MAX_ROUTERS_Y(MAX_ROUTERS_Y),
    .X_WIDTH      (X_WIDTH),
    .Y_WIDTH      (Y_WIDTH),
    .ROUTER_X     (ROUTER_X),
    .ROUTER_Y     (ROUTER_Y),
    .ROUTE_MODE   (ROUTE_MODE)
  ) u_route (
    .tx_i (in_mosi_i.tdata[HDR_X_LSB +: COORD_W]),
    .ty_i (in_mosi_i.tdata[HDR_Y_LSB +: COORD_W]),
    .ch_o (route_ch),
    .oor_o(oor)
  );

  always_comb begin
    sel_ready = 1'b0;
    for (int i = 0; i < CHANNEL_NUMBER; i++)
      if (ch_q == CH_W'(i)) sel_ready = out_miso_i[i].tready;
  end

  assign pop      = valid_q && sel_ready;
  assign in_ready = (state_q == DROP) || !valid_q || pop;
  assign in_acc   = in_mosi_i.tvalid && in_ready;
  assign is_hdr   = in_mosi_i.tid == ROUTING_HEADER;
  assign fwd_ok   = is_hdr && !oor;
  assign load     = in_acc && ((state_q == ROUTE) || (state_q == IDLE && fwd_ok));
  assign load_ch  = (state_q == ROUTE) ? sel_q : route_ch;

  assign in_miso_o = '{tready: in_ready};
  // A dropped packet's TLAST is flagged on its own acceptance cycle.
  assign drop_o    = in_acc && in_mosi_i.tlast &&
                     ((state_q == DROP) || (state_q == IDLE && !fwd_ok));

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      sel_q   <= CH_LOCAL;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_acc) begin
          if (!fwd_ok) begin
            state_q <= in_mosi_i.tlast ? IDLE : DROP;
          end else begin
            sel_q   <= route_ch;
            state_q <= in_mosi_i.tlast ? IDLE : ROUTE;
          end
        end
        ROUTE:   if (in_acc && in_mosi_i.tlast) state_q <= IDLE;
        DROP:    if (in_acc && in_mosi_i.tlast) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (load)     valid_q <= 1'b1;
      else if (pop) valid_q <= 1'b0;
    end
  end

  // NOTE: slice payload carries no reset; valid_q alone qualifies it on every output.
  always_ff @(posedge clk_i) begin
    if (load) begin
      beat_q <= in_mosi_i;
      ch_q   <= load_ch;
    end
  end

  always_comb begin
    for (int i = 0; i < CHANNEL_NUMBER; i++) begin
      out_mosi_o[i] = '0;
      lock_o[i]     = (state_q == ROUTE) && (sel_q == CH_W'(i));
      if (valid_q && ch_q == CH_W'(i)) out_mosi_o[i] = beat_q;
    end
  end

endmodule
